// File: rtl/sparse_coo_matmul_stream.sv
// Sparse COO matrix multiply C = A x B: buffers A/B entry streams, evaluates every pair, drains dense C row-major.
// Optional build macro SATURATE_ACC_EN selects unsigned saturating accumulation instead of modulo wrap.
module sparse_coo_matmul_stream #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 32,
    parameter int DIM     = 4,
    parameter int NNZ_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [DATA_W-1:0]          a_data,
    input  logic [$clog2(DIM)-1:0]     a_row,
    input  logic [$clog2(DIM)-1:0]     a_col,
    input  logic                       a_last,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [DATA_W-1:0]          b_data,
    input  logic [$clog2(DIM)-1:0]     b_row,
    input  logic [$clog2(DIM)-1:0]     b_col,
    input  logic                       b_last,
    output logic                       c_valid,
    input  logic                       c_ready,
    output logic [ACC_W-1:0]           c_data,
    output logic [$clog2(DIM)-1:0]     c_row,
    output logic [$clog2(DIM)-1:0]     c_col,
    output logic                       c_last,
    output logic                       busy,
    output logic                       overflow
);

    localparam int IDX_W  = $clog2(DIM);
    localparam int CNT_W  = $clog2(NNZ_MAX + 1);
    localparam int PTR_W  = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + PROD_W;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0]  row;
        logic [IDX_W-1:0]  col;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_a_q, n_a_d, n_b_q, n_b_d;
    logic              a_done_q, a_done_d, b_done_q, b_done_d;
    logic              overflow_q, overflow_d;
    logic [PTR_W-1:0]  i_q, i_d, j_q, j_d;
    logic [IDX_W-1:0]  dr_row_q, dr_row_d, dr_col_q, dr_col_d;
    logic              clear_c;

    entry_t            a_buf_q [NNZ_MAX];
    entry_t            b_buf_q [NNZ_MAX];
    logic [ACC_W-1:0]  c_q [DIM][DIM];

    entry_t            a_cur, b_cur;
    logic              acc_en;
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_new;
    logic              last_i, last_j;
    logic              a_fire, b_fire;

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;

    // Operand pair under evaluation during COMPUTE.
    assign a_cur  = a_buf_q[i_q];
    assign b_cur  = b_buf_q[j_q];
    assign last_i = (i_q == PTR_W'(n_a_q - CNT_W'(1)));
    assign last_j = (j_q == PTR_W'(n_b_q - CNT_W'(1)));
    assign acc_en = (state_q == ST_COMPUTE) && (a_cur.col == b_cur.row);

    assign prod = {{DATA_W{1'b0}}, a_cur.data} * {{DATA_W{1'b0}}, b_cur.data};
    assign sum  = {{PROD_W{1'b0}}, c_q[a_cur.row][b_cur.col]} + {{ACC_W{1'b0}}, prod};

`ifdef SATURATE_ACC_EN
    assign acc_new = (|sum[SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_new = sum[ACC_W-1:0];
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        n_a_d      = n_a_q;
        n_b_d      = n_b_q;
        a_done_d   = a_done_q;
        b_done_d   = b_done_q;
        overflow_d = overflow_q;
        i_d        = i_q;
        j_d        = j_q;
        dr_row_d   = dr_row_q;
        dr_col_d   = dr_col_q;
        clear_c    = 1'b0;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        c_valid    = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                a_ready = !a_done_q;
                b_ready = !b_done_q;
                if (a_valid && !a_done_q) begin
                    n_a_d = n_a_q + CNT_W'(1);
                    if (a_last || (n_a_d == CNT_W'(NNZ_MAX))) begin
                        a_done_d = 1'b1;
                    end
                    if (!a_last && (n_a_d == CNT_W'(NNZ_MAX))) begin
                        overflow_d = 1'b1;
                    end
                end
                if (b_valid && !b_done_q) begin
                    n_b_d = n_b_q + CNT_W'(1);
                    if (b_last || (n_b_d == CNT_W'(NNZ_MAX))) begin
                        b_done_d = 1'b1;
                    end
                    if (!b_last && (n_b_d == CNT_W'(NNZ_MAX))) begin
                        overflow_d = 1'b1;
                    end
                end
                if (a_done_q && b_done_q) begin
                    state_d = ST_COMPUTE;
                    i_d     = '0;
                    j_d     = '0;
                    clear_c = 1'b1;
                end
            end

            ST_COMPUTE: begin
                busy = 1'b1;
                if (last_j) begin
                    j_d = '0;
                    if (last_i) begin
                        state_d  = ST_DRAIN;
                        dr_row_d = '0;
                        dr_col_d = '0;
                    end else begin
                        i_d = i_q + PTR_W'(1);
                    end
                end else begin
                    j_d = j_q + PTR_W'(1);
                end
            end

            ST_DRAIN: begin
                busy    = 1'b1;
                c_valid = 1'b1;
                if (c_ready) begin
                    if (dr_col_q == IDX_W'(DIM - 1)) begin
                        dr_col_d = '0;
                        dr_row_d = dr_row_q + IDX_W'(1);
                    end else begin
                        dr_col_d = dr_col_q + IDX_W'(1);
                    end
                    if (c_last) begin
                        state_d  = ST_LOAD;
                        n_a_d    = '0;
                        n_b_d    = '0;
                        a_done_d = 1'b0;
                        b_done_d = 1'b0;
                        dr_row_d = '0;
                        dr_col_d = '0;
                    end
                end
            end

            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            n_a_q      <= '0;
            n_b_q      <= '0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            overflow_q <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            dr_row_q   <= '0;
            dr_col_q   <= '0;
        end else begin
            state_q    <= state_d;
            n_a_q      <= n_a_d;
            n_b_q      <= n_b_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            overflow_q <= overflow_d;
            i_q        <= i_d;
            j_q        <= j_d;
            dr_row_q   <= dr_row_d;
            dr_col_q   <= dr_col_d;
        end
    end

    // NOTE: operand buffers need no reset; entries are only read below the counts, which are reset.
    always_ff @(posedge clk) begin
        if (a_fire) begin
            a_buf_q[n_a_q[PTR_W-1:0]] <= {a_row, a_col, a_data};
        end
        if (b_fire) begin
            b_buf_q[n_b_q[PTR_W-1:0]] <= {b_row, b_col, b_data};
        end
    end

    // Accumulators are cleared on reset and again on entry to COMPUTE.
    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    c_q[r][c] <= '0;
                end
            end
        end else if (acc_en) begin
            c_q[a_cur.row][b_cur.col] <= acc_new;
        end
    end

    assign c_row    = c_valid ? dr_row_q : '0;
    assign c_col    = c_valid ? dr_col_q : '0;
    assign c_data   = c_valid ? c_q[dr_row_q][dr_col_q] : '0;
    assign c_last   = c_valid && (dr_row_q == IDX_W'(DIM - 1)) && (dr_col_q == IDX_W'(DIM - 1));
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sparse_coo_matmul_stream.sv
// Scoreboard bench for sparse_coo_matmul_stream: directed and random COO operands against a dense reference model.
module tb_sparse_coo_matmul_stream;

    localparam int DIM = 4;
    localparam int NNZ = 8;

    logic        clk, rst;
    logic        a_valid, a_ready, a_last;
    logic [31:0] a_data;
    logic [1:0]  a_row, a_col;
    logic        b_valid, b_ready, b_last;
    logic [31:0] b_data;
    logic [1:0]  b_row, b_col;
    logic        c_valid, c_ready, c_last;
    logic [31:0] c_data;
    logic [1:0]  c_row, c_col;
    logic        busy, overflow;

    sparse_coo_matmul_stream #(
        .DATA_W(32), .ACC_W(32), .DIM(DIM), .NNZ_MAX(NNZ)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_row(a_row), .a_col(a_col), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_row(b_row), .b_col(b_col), .b_last(b_last),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_row(c_row), .c_col(c_col), .c_last(c_last),
        .busy(busy), .overflow(overflow)
    );

    typedef struct packed {
        logic [1:0]  row;
        logic [1:0]  col;
        logic [31:0] data;
        logic        last;
    } ent_t;

    ent_t        qa[$];
    ent_t        qb[$];
    logic [36:0] sb[$];
    int          n_pass = 0;
    int          n_checks = 0;
    int          comp_cnt = 0;
    int          hs_cnt = 0;
    int          bp_mode = 0;
    bit          ovf_sticky = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic ent_t mk(input int r, input int c, input logic [31:0] d, input bit l);
        ent_t e;
        e.row  = 2'(r);
        e.col  = 2'(c);
        e.data = d;
        e.last = l;
        return e;
    endfunction

    // Consumer backpressure: 0 always ready, 1 toggling, 2 random.
    initial begin
        c_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       c_ready = 1'b1;
                1:       c_ready = ~c_ready;
                default: c_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Monitor: every presented C beat must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy && !c_valid) comp_cnt++;
                if (c_valid) begin
                    if (sb.size() == 0) begin
                        check("c_unexpected", 64'(c_valid), 64'd0);
                    end else begin
                        check("c_beat", 64'({c_last, c_row, c_col, c_data}), 64'(sb[0]));
                        if (c_ready) begin
                            void'(sb.pop_front());
                            hs_cnt++;
                        end
                    end
                end
            end
        end
    end

    // Dense reference: C[a.row][b.col] += a*b over every matching pair of stored entries.
    task automatic build_expected(output int na, output int nb);
        logic [63:0] cm [DIM][DIM];
        logic [63:0] x, y, s;
        na = 0;
        for (int i = 0; i < qa.size() && na < NNZ; i++) begin
            na++;
            if (qa[i].last) break;
        end
        nb = 0;
        for (int i = 0; i < qb.size() && nb < NNZ; i++) begin
            nb++;
            if (qb[i].last) break;
        end
        if (na == NNZ && !qa[na-1].last) ovf_sticky = 1;
        if (nb == NNZ && !qb[nb-1].last) ovf_sticky = 1;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) cm[r][c] = 0;
        for (int i = 0; i < na; i++) begin
            for (int j = 0; j < nb; j++) begin
                if (qa[i].col == qb[j].row) begin
                    x = 64'(qa[i].data);
                    y = 64'(qb[j].data);
                    s = cm[qa[i].row][qb[j].col] + x * y;
`ifdef SATURATE_ACC_EN
                    cm[qa[i].row][qb[j].col] = (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
`else
                    cm[qa[i].row][qb[j].col] = s & 64'hFFFF_FFFF;
`endif
                end
            end
        end
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                sb.push_back({(r == DIM-1 && c == DIM-1), 2'(r), 2'(c), cm[r][c][31:0]});
            end
        end
    endtask

    task automatic feed_operands();
        int  ai = 0;
        int  bi = 0;
        int  cyc = 0;
        bit  a_acc, b_acc;
        while ((ai < qa.size() || bi < qb.size()) && cyc < 500) begin
            if (ai < qa.size() && $urandom_range(3) != 0) begin
                a_valid = 1; a_row = qa[ai].row; a_col = qa[ai].col;
                a_data = qa[ai].data; a_last = qa[ai].last;
            end else begin
                a_valid = 0;
            end
            if (bi < qb.size() && $urandom_range(3) != 0) begin
                b_valid = 1; b_row = qb[bi].row; b_col = qb[bi].col;
                b_data = qb[bi].data; b_last = qb[bi].last;
            end else begin
                b_valid = 0;
            end
            @(negedge clk);
            a_acc = a_valid && a_ready;
            b_acc = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (a_acc) ai++;
            if (b_acc) bi++;
            cyc++;
        end
        a_valid = 0;
        b_valid = 0;
        if (cyc >= 500) check("feed_timeout", 64'(ai + bi), 64'(qa.size() + qb.size()));
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        if (sb.size() != 0) check({name, "_drain_timeout"}, 64'(sb.size()), 64'd0);
        #1;
    endtask

    task automatic run_case(input string name, input int mode);
        int na, nb;
        bp_mode  = mode;
        sb.delete();
        build_expected(na, nb);
        comp_cnt = 0;
        hs_cnt   = 0;
        feed_operands();
        check({name, "_ready_after_load"}, 64'({a_ready, b_ready}), 64'd0);
        check({name, "_overflow_load"}, 64'(overflow), 64'(ovf_sticky));
        wait_drain(name);
        check({name, "_compute_cycles"}, 64'(comp_cnt), 64'(na * nb));
        check({name, "_handshakes"}, 64'(hs_cnt), 64'(DIM * DIM));
        @(negedge clk);
        check({name, "_idle"}, 64'({a_ready, b_ready, busy, c_valid}), 64'b1100);
        check({name, "_overflow_end"}, 64'(overflow), 64'(ovf_sticky));
        @(posedge clk);
        #1;
    endtask

    task automatic set_basic();
        qa.delete(); qb.delete();
        qa.push_back(mk(0, 1, 2, 0)); qa.push_back(mk(1, 2, 3, 0)); qa.push_back(mk(2, 3, 4, 1));
        qb.push_back(mk(1, 0, 5, 0)); qb.push_back(mk(2, 1, 6, 0)); qb.push_back(mk(3, 2, 7, 1));
    endtask

    task automatic set_random();
        int n;
        qa.delete(); qb.delete();
        n = $urandom_range(NNZ, 1);
        for (int i = 0; i < n; i++)
            qa.push_back(mk($urandom_range(3), $urandom_range(3),
                            ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(255)), i == n-1));
        n = $urandom_range(NNZ, 1);
        for (int i = 0; i < n; i++)
            qb.push_back(mk($urandom_range(3), $urandom_range(3),
                            ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(255)), i == n-1));
    endtask

    initial begin
        int cyc;
        rst = 1; a_valid = 0; b_valid = 0;
        a_data = 0; a_row = 0; a_col = 0; a_last = 0;
        b_data = 0; b_row = 0; b_col = 0; b_last = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", 64'({a_ready, b_ready, c_valid, busy, overflow, c_last}), 64'b110000);
        check("reset_c_fields", 64'({c_data, c_row, c_col}), 64'd0);
        @(posedge clk);
        #1 rst = 0;

        set_basic();
        run_case("basic", 0);
        set_basic();
        run_case("backpressure", 1);

        qa.delete(); qb.delete();
        qa.push_back(mk(0, 0, 3, 0)); qa.push_back(mk(0, 1, 4, 1));
        qb.push_back(mk(0, 0, 5, 0)); qb.push_back(mk(1, 0, 6, 1));
        run_case("duplicates", 0);

        qa.delete(); qb.delete();
        for (int i = 0; i < NNZ; i++) qa.push_back(mk(i % DIM, (i + 1) % DIM, 32'(i + 1), 0));
        qb.push_back(mk(1, 3, 9, 1));
        run_case("overflow", 2);

        qa.delete(); qb.delete();
        qa.push_back(mk(0, 0, 32'hFFFF_FFFF, 0)); qa.push_back(mk(0, 0, 32'hFFFF_FFFF, 1));
        qb.push_back(mk(0, 0, 2, 1));
        run_case("wrap_sat", 0);

        // Reset in the middle of COMPUTE discards everything, including the sticky overflow.
        set_basic();
        bp_mode  = 0;
        comp_cnt = 0;
        feed_operands();
        cyc = 0;
        while (comp_cnt < 3 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        check("rst_reached_compute", 64'(comp_cnt >= 3), 64'd1);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        sb.delete();
        ovf_sticky = 0;
        @(negedge clk);
        check("rst_mid_compute", 64'({a_ready, b_ready, busy, c_valid}), 64'b1100);
        check("rst_clears_overflow", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        set_basic();
        run_case("basic_after_rst", 0);

        for (int t = 0; t < 8; t++) begin
            set_random();
            run_case("random", 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
